// File: rtl/temp_pkg.sv
// Shared types, widths and helpers for the temperature BCD converter.
package temp_pkg;

   localparam int unsigned RAW_W    = 24;
   localparam int unsigned BCD_MAX  = 9999;
   localparam int unsigned BIN_W    = 14;
   localparam int unsigned N_DIGITS = 4;
   localparam int unsigned BCD_W    = 4 * N_DIGITS;
   localparam int unsigned DD_ITER  = 14;
   localparam int unsigned CNT_W    = 4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   // One scaled sample with its clamp flag, as carried through the pending slot.
   typedef struct packed {
      logic             sat;
      logic [BIN_W-1:0] bin;
   } sample_t;

   // Clamp a scaled readout to the 4-digit display range.
   function automatic sample_t make_sample(input logic [RAW_W-1:0] v);
      sample_t s;
      if (v > RAW_W'(BCD_MAX)) begin
         s.sat = 1'b1;
         s.bin = BIN_W'(BCD_MAX);
      end else begin
         s.sat = 1'b0;
         s.bin = v[BIN_W-1:0];
      end
      return s;
   endfunction

endpackage

// File: rtl/bcd_dd_step.sv
// One double-dabble iteration: add 3 to each digit >= 5, then shift {digits, bin} left.
module bcd_dd_step
   import temp_pkg::*;
(
   input  logic [BCD_W-1:0] i_digits,
   input  logic [BIN_W-1:0] i_bin,
   output logic [BCD_W-1:0] o_digits,
   output logic [BIN_W-1:0] o_bin
);

   logic [BCD_W-1:0] w_adj;

   // Per-digit add-3 correction so the following shift stays in decimal.
   always_comb begin
      w_adj = i_digits;
      for (int d = 0; d < int'(N_DIGITS); d++) begin
         if (i_digits[4*d +: 4] >= 4'd5) begin
            w_adj[4*d +: 4] = i_digits[4*d +: 4] + 4'd3;
         end
      end
   end

   assign o_digits = {w_adj[BCD_W-2:0], i_bin[BIN_W-1]};
   assign o_bin    = {i_bin[BIN_W-2:0], 1'b0};

endmodule

// File: rtl/temp_bcd_converter.sv
// Sensor readout to packed BCD: edge-triggered capture, clamp, 14-step double-dabble,
// with a one-deep pending slot so samples arriving mid-conversion are not lost.
module temp_bcd_converter
   import temp_pkg::*;
#(
   parameter int unsigned SHIFT = 8
) (
   input  logic             clk_in,
   input  logic             rst,
   input  logic [RAW_W-1:0] raw_code,
   input  logic             new_data_trigger,
   output logic [BCD_W-1:0] bcd_values,
   output logic             bcd_valid,
   output logic             busy,
   output logic             saturated,
   output logic             overrun
);

   state_t           r_state, w_state_nxt;
   logic             r_trig_q;
   logic [BCD_W-1:0] r_digits, w_digits_nxt;
   logic [BIN_W-1:0] r_bin, w_bin_nxt;
   logic             r_sat, w_sat_nxt;
   logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
   logic             r_pend_vld, w_pend_vld_nxt;
   sample_t          r_pend, w_pend_nxt;
   logic [BCD_W-1:0] r_bcd, w_bcd_nxt;
   logic             r_bcd_valid, w_bcd_valid_nxt;
   logic             r_busy, w_busy_nxt;
   logic             r_saturated, w_saturated_nxt;
   logic             r_overrun, w_overrun_nxt;

   logic             w_edge;
   logic [RAW_W-1:0] w_v;
   sample_t          w_new;
   logic [BCD_W-1:0] w_step_digits;
   logic [BIN_W-1:0] w_step_bin;

   assign w_edge = new_data_trigger & ~r_trig_q;
   assign w_v    = raw_code >> SHIFT;
   assign w_new  = make_sample(w_v);

   bcd_dd_step u_step (
      .i_digits (r_digits),
      .i_bin    (r_bin),
      .o_digits (w_step_digits),
      .o_bin    (w_step_bin)
   );

   // State and datapath registers; trigger history follows the input even in reset.
   always_ff @(posedge clk_in) begin
      r_trig_q <= new_data_trigger;
      if (rst) begin
         r_state     <= ST_IDLE;
         r_digits    <= '0;
         r_bin       <= '0;
         r_sat       <= 1'b0;
         r_cnt       <= '0;
         r_pend_vld  <= 1'b0;
         r_pend      <= '0;
         r_bcd       <= '0;
         r_bcd_valid <= 1'b0;
         r_busy      <= 1'b0;
         r_saturated <= 1'b0;
         r_overrun   <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_digits    <= w_digits_nxt;
         r_bin       <= w_bin_nxt;
         r_sat       <= w_sat_nxt;
         r_cnt       <= w_cnt_nxt;
         r_pend_vld  <= w_pend_vld_nxt;
         r_pend      <= w_pend_nxt;
         r_bcd       <= w_bcd_nxt;
         r_bcd_valid <= w_bcd_valid_nxt;
         r_busy      <= w_busy_nxt;
         r_saturated <= w_saturated_nxt;
         r_overrun   <= w_overrun_nxt;
      end
   end

   // Next-state, conversion datapath, pending slot and output strobes.
   always_comb begin
      w_state_nxt     = r_state;
      w_digits_nxt    = r_digits;
      w_bin_nxt       = r_bin;
      w_sat_nxt       = r_sat;
      w_cnt_nxt       = r_cnt;
      w_pend_vld_nxt  = r_pend_vld;
      w_pend_nxt      = r_pend;
      w_bcd_nxt       = r_bcd;
      w_bcd_valid_nxt = 1'b0;
      w_saturated_nxt = r_saturated;
      w_overrun_nxt   = 1'b0;

      unique case (r_state)
         ST_IDLE: begin
            if (w_edge) begin
               w_digits_nxt = '0;
               w_bin_nxt    = w_new.bin;
               w_sat_nxt    = w_new.sat;
               w_cnt_nxt    = '0;
               w_state_nxt  = ST_SHIFT;
            end
         end

         ST_SHIFT: begin
            w_digits_nxt = w_step_digits;
            w_bin_nxt    = w_step_bin;
            w_cnt_nxt    = r_cnt + CNT_W'(1);
            if (r_cnt == CNT_W'(DD_ITER - 1)) begin
               w_state_nxt = ST_DONE;
            end
            if (w_edge) begin
               w_pend_nxt     = w_new;
               w_pend_vld_nxt = 1'b1;
               w_overrun_nxt  = r_pend_vld;
            end
         end

         ST_DONE: begin
            w_bcd_nxt       = r_digits;
            w_saturated_nxt = r_sat;
            w_bcd_valid_nxt = 1'b1;
            w_digits_nxt    = '0;
            w_cnt_nxt       = '0;
            if (r_pend_vld) begin
               // Chain the pending sample; a same-cycle edge refills the freed slot.
               w_bin_nxt      = r_pend.bin;
               w_sat_nxt      = r_pend.sat;
               w_state_nxt    = ST_SHIFT;
               w_pend_vld_nxt = w_edge;
               if (w_edge) begin
                  w_pend_nxt = w_new;
               end
            end else if (w_edge) begin
               // Slot is empty, so the new sample goes straight into the shifter.
               w_bin_nxt   = w_new.bin;
               w_sat_nxt   = w_new.sat;
               w_state_nxt = ST_SHIFT;
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end

         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase

      w_busy_nxt = (w_state_nxt != ST_IDLE);
   end

   assign bcd_values = r_bcd;
   assign bcd_valid  = r_bcd_valid;
   assign busy       = r_busy;
   assign saturated  = r_saturated;
   assign overrun    = r_overrun;

endmodule

// File: tb/tb_temp_bcd_converter.sv
// Directed bench for temp_bcd_converter with hand-computed expected BCD values.
module tb_temp_bcd_converter;

   logic        clk_in;
   logic        rst;
   logic [23:0] raw_code;
   logic        new_data_trigger;
   logic [15:0] bcd_values;
   logic        bcd_valid;
   logic        busy;
   logic        saturated;
   logic        overrun;

   int n_checks;
   int n_pass;
   int v_count;
   int ov_count;

   temp_bcd_converter #(.SHIFT(8)) dut (
      .clk_in           (clk_in),
      .rst              (rst),
      .raw_code         (raw_code),
      .new_data_trigger (new_data_trigger),
      .bcd_values       (bcd_values),
      .bcd_valid        (bcd_valid),
      .busy             (busy),
      .saturated        (saturated),
      .overrun          (overrun)
   );

   initial clk_in = 1'b0;
   always #5 clk_in = ~clk_in;

   // Count strobes mid-cycle, away from the active edge.
   initial begin
      v_count  = 0;
      ov_count = 0;
   end
   always @(negedge clk_in) begin
      if (bcd_valid) v_count <= v_count + 1;
      if (overrun)   ov_count <= ov_count + 1;
   end

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end else begin
         n_pass++;
      end
   endtask

   // Single isolated conversion: edge at k, result and strobe right after k+15.
   task automatic convert(input logic [23:0] raw, input logic [15:0] exp,
                          input logic exp_sat, input string tag);
      int busy_lo;
      int early;
      busy_lo = 0;
      early   = 0;
      raw_code = raw;
      new_data_trigger = 1'b1;
      tick();
      new_data_trigger = 1'b0;
      for (int i = 0; i < 15; i++) begin
         if (!busy) busy_lo++;
         if (bcd_valid) early++;
         tick();
      end
      check({tag, "_busy_gap"}, 32'(busy_lo), 32'd0);
      check({tag, "_early_valid"}, 32'(early), 32'd0);
      check({tag, "_valid"}, 32'(bcd_valid), 32'd1);
      check({tag, "_bcd"}, 32'(bcd_values), 32'(exp));
      check({tag, "_sat"}, 32'(saturated), 32'(exp_sat));
      check({tag, "_busy_fall"}, 32'(busy), 32'd0);
      tick();
      check({tag, "_valid_1cyc"}, 32'(bcd_valid), 32'd0);
   endtask

   initial begin
      int base_v;
      int base_ov;
      n_checks = 0;
      n_pass   = 0;
      rst = 1'b1;
      raw_code = 24'h0;
      new_data_trigger = 1'b0;
      repeat (3) tick();
      check("rst_bcd", 32'(bcd_values), 32'h0);
      check("rst_valid", 32'(bcd_valid), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_sat", 32'(saturated), 32'd0);
      check("rst_ovr", 32'(overrun), 32'd0);
      rst = 1'b0;
      tick();

      convert(24'h001A00, 16'h0026, 1'b0, "v26");
      convert(24'h270F00, 16'h9999, 1'b0, "v9999");
      convert(24'h271000, 16'h9999, 1'b1, "v10000");
      convert(24'h000000, 16'h0000, 1'b0, "v0");
      convert(24'h04D2FF, 16'h1234, 1'b0, "v1234");
      convert(24'hFFFFFF, 16'h9999, 1'b1, "vmax");

      // Level held high: one edge, one conversion.
      base_v = v_count;
      raw_code = 24'h000500;
      new_data_trigger = 1'b1;
      repeat (40) tick();
      new_data_trigger = 1'b0;
      repeat (5) tick();
      check("hold_pulses", 32'(v_count - base_v), 32'd1);
      check("hold_bcd", 32'(bcd_values), 32'h0005);

      // Edges at k (12), k+3 (34), k+5 (56): 34 is dropped with one overrun.
      base_v  = v_count;
      base_ov = ov_count;
      raw_code = 24'h000C00; new_data_trigger = 1'b1; tick();   // k
      new_data_trigger = 1'b0; tick(); tick();                   // k+2
      raw_code = 24'h002200; new_data_trigger = 1'b1; tick();   // k+3
      new_data_trigger = 1'b0; tick();                           // k+4
      raw_code = 24'h003800; new_data_trigger = 1'b1; tick();   // k+5
      new_data_trigger = 1'b0;
      check("ovr_pulse", 32'(overrun), 32'd1);
      tick();                                                    // k+6
      check("ovr_1cyc", 32'(overrun), 32'd0);
      repeat (9) tick();                                         // k+15
      check("chain1_valid", 32'(bcd_valid), 32'd1);
      check("chain1_bcd", 32'(bcd_values), 32'h0012);
      check("chain1_busy", 32'(busy), 32'd1);
      repeat (15) tick();                                        // k+30
      check("chain2_valid", 32'(bcd_valid), 32'd1);
      check("chain2_bcd", 32'(bcd_values), 32'h0056);
      repeat (20) tick();
      check("chain_pulses", 32'(v_count - base_v), 32'd2);
      check("chain_ovr_cnt", 32'(ov_count - base_ov), 32'd1);

      // Reset mid-conversion cancels the result.
      base_v = v_count;
      raw_code = 24'h000900; new_data_trigger = 1'b1; tick();   // k
      new_data_trigger = 1'b0;
      repeat (6) tick();                                         // k+6
      rst = 1'b1; tick();                                        // k+7
      rst = 1'b0;
      check("mrst_busy", 32'(busy), 32'd0);
      check("mrst_bcd", 32'(bcd_values), 32'h0);
      repeat (20) tick();
      check("mrst_pulses", 32'(v_count - base_v), 32'd0);
      convert(24'h003000, 16'h0048, 1'b0, "post_rst");

      // Second edge landing exactly in the DONE cycle, no prior pending.
      base_ov = ov_count;
      raw_code = 24'h000700; new_data_trigger = 1'b1; tick();   // k
      new_data_trigger = 1'b0;
      repeat (14) tick();                                        // k+14
      raw_code = 24'h000800; new_data_trigger = 1'b1; tick();   // k+15
      new_data_trigger = 1'b0;
      check("done_edge_valid1", 32'(bcd_valid), 32'd1);
      check("done_edge_bcd1", 32'(bcd_values), 32'h0007);
      check("done_edge_busy", 32'(busy), 32'd1);
      repeat (15) tick();                                        // k+30
      check("done_edge_valid2", 32'(bcd_valid), 32'd1);
      check("done_edge_bcd2", 32'(bcd_values), 32'h0008);
      repeat (3) tick();
      check("done_edge_no_ovr", 32'(ov_count - base_ov), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/temp_bcd_converter.md
# temp_bcd_converter

Sequential binary-to-BCD converter between the temperature-sensor SPI stage and the e-ink glyph renderer. On each completed sensor transaction it captures the raw readout word, scales and saturates it to 0–9999, and converts it with a 14-iteration double-dabble. It then presents four packed BCD digits with a one-cycle valid strobe. A single pending slot absorbs a new sample that arrives mid-conversion.

## Interface
- SHIFT, 8: right-shift applied to raw_code before conversion, which drops fractional/status bits. Legal range 0–10.
- clk_in  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- raw_code  input  24  sensor readout word; sampled only on a trigger edge.
- new_data_trigger  input  1  transaction-done level from the SPI stage; a rising edge requests conversion.
- bcd_values  output  16  packed BCD: [15:12] thousands, [11:8] hundreds, [7:4] tens, [3:0] units.
- bcd_valid  output  1  one-cycle pulse when bcd_values updates.
- busy  output  1  high while in SHIFT or DONE.
- saturated  output  1  registered with bcd_values; 1 if the last converted value was clamped.
- overrun  output  1  one-cycle pulse when a pending sample is overwritten.

## Operation
- Edge detect: trig_q <= new_data_trigger every cycle; edge = new_data_trigger & ~trig_q.
- Value path: v = raw_code >> SHIFT. If v > 9999, the converter uses 9999 (14 bits) and sets a sat flag that is carried with the sample.
- States:
  - IDLE: on edge, capture v and sat into the shift register, cnt <= 0, go to SHIFT.
  - SHIFT: one double-dabble iteration per cycle. Each digit ≥5 gets +3, then the {digits, bin} register shifts left 1. After the iteration with cnt = 13, go to DONE.
  - DONE: bcd_values <= digits; saturated <= sat; bcd_valid <= 1. If pending is set, capture the pending sample, clear pending, and go to SHIFT. Otherwise go to IDLE.
- Pending slot, one deep:
  - An edge in SHIFT or DONE stores the current v/sat into pending.
  - If pending is already full, the new sample overwrites it and overrun pulses. Newest sample wins.
  - In DONE, when pending is consumed and a new edge arrives in the same cycle, the new sample refills pending. No overrun in that case.
- Reset, applied even mid-conversion:
  - Cleared: state IDLE, bcd_values 0x0000, bcd_valid 0, busy 0, saturated 0, overrun 0, pending cleared, digits and cnt 0.
  - trig_q <= new_data_trigger, so a level held through reset is not an edge.

## Timing
- Edge seen at clock edge k → SHIFT iterations at k+1..k+14 → DONE at k+15.
- bcd_values and saturated are updated at k+15. bcd_valid is high for exactly the cycle following k+15.
- Fixed latency: 15 cycles. Throughput: one conversion per 15 cycles when pending is used back-to-back. No IDLE cycle is inserted between chained conversions.
- busy is registered: high from k+1 through the DONE cycle; it falls after k+15 if no pending sample.
- overrun is asserted the cycle after the overwriting edge, for one cycle.
- bcd_values holds its value between conversions. Intermediate digits are never visible.

## Structure
- Shared package (temp_pkg):
  - State encodings IDLE/SHIFT/DONE, 2 bits.
  - BCD_MAX = 9999, BIN_W = 14, N_DIGITS = 4, DD_ITER = 14.
- Sub-module bcd_dd_step: combinational single double-dabble iteration (add-3 on four digits, then shift). Inputs are the 16-bit digits and the 14-bit bin; outputs are the next digits and next bin. The top FSM instantiates it once.
- The converter is the direct producer of bcd_values for the e-ink renderer.

## Test plan
- raw_code = 0x001A00, SHIFT = 8, single edge at k → bcd_values = 0x0026 at k+15, bcd_valid one cycle, saturated = 0, busy high k+1..k+15.
- raw_code = 0x270F00 → 0x9999, saturated = 0. Then raw_code = 0x271000 → 0x9999, saturated = 1.
- new_data_trigger held high 40 cycles → exactly one conversion and one bcd_valid pulse.
- Edges at k (v = 12), k+3 (v = 34), k+5 (v = 56):
  - overrun pulses once, after the k+5 edge.
  - 0x0012 at k+15, 0x0056 at k+30.
  - 34 is never output.
- Edge at k, then rst at k+7 for one cycle → busy 0 and bcd_values 0x0000 with no bcd_valid. A later edge converts correctly 15 cycles after it.
- Edge at k (v = 7), second edge exactly in the DONE cycle k+15 (v = 8), no prior pending → 0x0007 at k+15, 0x0008 at k+30, no overrun.
